// File: rtl/clocks_multiphase_if.sv
// Control and output bundle of the multiphase core-clock generator.
// master = the generator, slave = the core / controller side.
interface clocks_multiphase_if #(
  parameter int NPHASE = 4,
  parameter int DIVW   = 8
);
  localparam int PW = $clog2(NPHASE);

  logic [DIVW-1:0] div;
  logic            run;
  logic            rst_req;
  logic            reset;
  logic            clk1;
  logic            clk2;
  logic [PW-1:0]   phase;
  logic            cycle_start;
  logic            running;

  modport master (
    input  div, run, rst_req,
    output reset, clk1, clk2, phase, cycle_start, running
  );

  modport slave (
    output div, run, rst_req,
    input  reset, clk1, clk2, phase, cycle_start, running
  );
endinterface

// File: rtl/clocks_multiphase.sv
// Generates non-overlapping multiphase core clocks from eclk plus a held core reset.
// All outputs come straight from flops; cycles are never truncated except by ereset_n.
module clocks_multiphase #(
  parameter int NPHASE       = 4,
  parameter int DIVW         = 8,
  parameter int CLK2_PHASE   = 2,
  parameter int RESET_CYCLES = 2048
) (
  input  logic                eclk,
  input  logic                ereset_n,
  clocks_multiphase_if.master bus
);
  localparam int PW = $clog2(NPHASE);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] PLAST = PW'(NPHASE - 1);
  localparam logic [PW-1:0] P2    = PW'(CLK2_PHASE);
  localparam logic [HW-1:0] RC    = HW'(RESET_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t          state_q;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] cnt_q;
  logic [PW-1:0]   phase_q;
  logic            clk1_q;
  logic            clk2_q;
  logic            cs_q;
  logic            running_q;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   hold_d;
  logic            reset_q;
  logic            reset_d;

  logic [DIVW-1:0] div_eff;
  logic [PW-1:0]   phase_inc;
  logic            phase_end;

  assign div_eff   = (bus.div == '0) ? DIVW'(1) : bus.div;
  assign phase_inc = phase_q + PW'(1);
  // div_q is never 0, so div_q-1 cannot underflow and cnt_q never exceeds it.
  assign phase_end = (cnt_q == div_q - DIVW'(1));

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state_q   <= IDLE;
      div_q     <= DIVW'(1);
      cnt_q     <= '0;
      phase_q   <= '0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      cs_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q   <= RUN;
            div_q     <= div_eff;
            cnt_q     <= '0;
            phase_q   <= '0;
            clk1_q    <= 1'b1;
            clk2_q    <= 1'b0;
            cs_q      <= 1'b1;
            running_q <= 1'b1;
          end
        end
        default: begin
          cs_q <= 1'b0;
          if (!phase_end) begin
            cnt_q   <= cnt_q + DIVW'(1);
            state_q <= bus.run ? RUN : STOPPING;
          end else if (phase_q != PLAST) begin
            cnt_q   <= '0;
            phase_q <= phase_inc;
            clk1_q  <= 1'b0;
            clk2_q  <= (phase_inc == P2);
            state_q <= bus.run ? RUN : STOPPING;
          end else if (bus.run) begin
            // Cycle boundary with run still requested: the only point div is re-latched.
            state_q <= RUN;
            div_q   <= div_eff;
            cnt_q   <= '0;
            phase_q <= '0;
            clk1_q  <= 1'b1;
            clk2_q  <= 1'b0;
            cs_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            running_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Hold counter saturates at RESET_CYCLES; rst_req restarts the hold window.
  always_comb begin
    hold_d = hold_q;
    if (bus.rst_req) begin
      hold_d = '0;
    end else if (hold_q != RC) begin
      hold_d = hold_q + HW'(1);
    end
    reset_d = (hold_d != RC);
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      hold_q  <= '0;
      reset_q <= 1'b1;
    end else begin
      hold_q  <= hold_d;
      reset_q <= reset_d;
    end
  end

  assign bus.reset       = reset_q;
  assign bus.clk1        = clk1_q;
  assign bus.clk2        = clk2_q;
  assign bus.phase       = phase_q;
  assign bus.cycle_start = cs_q;
  assign bus.running     = running_q;
endmodule

// File: doc/clocks_multiphase.md
CLOCKS_MULTIPHASE -- requirements
Module: clocks_multiphase

Interface
REQ-001 SHALL have parameter NPHASE, default 4, phases per core cycle (legal 2..16).
REQ-002 SHALL have parameter DIVW, default 8, width of the phase-length divisor.
REQ-003 SHALL have parameter CLK2_PHASE, default 2, phase index in which clk2 is high (legal 1..NPHASE-1).
REQ-004 SHALL have parameter RESET_CYCLES, default 2048, core-reset hold length in eclk cycles (legal >= 1).
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-006 SHALL have port eclk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port ereset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port div, input, DIVW, phase length in eclk cycles; 0 treated as 1.
REQ-009 SHALL have port run, input, 1, level request to generate core clocks.
REQ-010 SHALL have port rst_req, input, 1, synchronous request to re-issue core reset.
REQ-011 SHALL have port reset, output, 1, core reset, active-high.
REQ-012 SHALL have port clk1, output, 1, high throughout phase 0 while generating.
REQ-013 SHALL have port clk2, output, 1, high throughout phase CLK2_PHASE while generating.
REQ-014 SHALL have port phase, output, clog2(NPHASE), current phase index.
REQ-015 SHALL have port cycle_start, output, 1, one-eclk pulse on the first eclk of each phase 0.
REQ-016 SHALL have port running, output, 1, high in RUN and STOPPING.

Function
REQ-017 SHALL implement states IDLE, RUN, STOPPING.
REQ-018 IDLE: clk1=clk2=0, phase=0, phase counter=0, cycle_start=0.
REQ-019 IDLE with run=1 at edge k: -> RUN; div latched into div_q (0->1); first eclk of phase 0 starts at edge k, so clk1=1 and cycle_start=1 after edge k.
REQ-020 RUN: each phase lasts exactly div_q eclk cycles; phase advances 0..NPHASE-1 and wraps to 0.
REQ-021 div SHALL be re-latched only on the edge that enters phase 0; mid-cycle changes of div take effect at the next cycle boundary.
REQ-022 RUN with run=0 sampled: -> STOPPING; current cycle completes unchanged.
REQ-023 STOPPING: on the edge ending phase NPHASE-1 -> IDLE (no partial cycles); if run=1 is sampled first -> RUN with no gap or glitch.
REQ-024 Simultaneous end of phase NPHASE-1 and run=1 in STOPPING: SHALL continue to phase 0 in RUN.
REQ-025 clk1, clk2, phase, cycle_start, running SHALL be driven directly from flops (no combinational decode on outputs).
REQ-026 clk1 and clk2 SHALL never be high in the same eclk cycle.
REQ-027 Hold counter SHALL count eclk edges after ereset_n release, saturate at RESET_CYCLES, never wrap.
REQ-028 reset SHALL be 1 until the RESET_CYCLES-th eclk edge after ereset_n release, then 0 from that edge on.
REQ-029 rst_req=1 sampled: reset=1 and hold counter=0 after that edge; reset deasserts RESET_CYCLES edges after the last edge rst_req was sampled high.
REQ-030 reset generation SHALL be independent of state; clocks run during core reset if run=1.
REQ-031 Phase counter width SHALL be DIVW; div_q=2^DIVW-1 SHALL work without overflow.

Reset
REQ-032 ereset_n=0 SHALL immediately, without eclk, force: state=IDLE, reset=1, clk1=clk2=0, phase=0, cycle_start=0, running=0, hold counter=0, div_q=1.
REQ-033 Assertion mid-cycle SHALL truncate the cycle with no further output pulses; release SHALL resume per REQ-019 and REQ-028.

Verification
REQ-034 Defaults, div=3, run=1 held: clk1 high 3 eclk, low 9; clk2 high eclk 7-9 of each 12-eclk cycle; cycle_start every 12 eclk.
REQ-035 ereset_n released, run=0: reset=1 for exactly 2048 edges then 0; clk1=clk2=0 throughout.
REQ-036 div changed 3->5 during phase 1: current cycle 12 eclk, next cycle 20 eclk.
REQ-037 run dropped in phase 1: cycle completes through phase 3, then IDLE, running=0; run re-raised in phase 2 of a stopping cycle: no gap, phase 0 follows phase 3.
REQ-038 div=0: behaves as div=1, 4-eclk cycle; rst_req pulse at edge 3000: reset=1 from edge 3000 until edge 5048.
REQ-039 ereset_n asserted mid-phase 2 with clk2=1: clk2, reset, running settle to 0/1/0 before the next eclk edge.
